// File: rtl/fft_output_serializer.sv
// Output reader for the 8-point FFT: captures a parallel frame in one cycle into
// ping-pong banks and streams it out one complex sample per valid/ready beat.
module fft_output_serializer #(
    parameter int WIDTH   = 16,
    parameter bit REORDER = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x_in_0_real,
    input  logic [WIDTH-1:0] x_in_1_real,
    input  logic [WIDTH-1:0] x_in_2_real,
    input  logic [WIDTH-1:0] x_in_3_real,
    input  logic [WIDTH-1:0] x_in_4_real,
    input  logic [WIDTH-1:0] x_in_5_real,
    input  logic [WIDTH-1:0] x_in_6_real,
    input  logic [WIDTH-1:0] x_in_7_real,
    input  logic [WIDTH-1:0] x_in_0_imag,
    input  logic [WIDTH-1:0] x_in_1_imag,
    input  logic [WIDTH-1:0] x_in_2_imag,
    input  logic [WIDTH-1:0] x_in_3_imag,
    input  logic [WIDTH-1:0] x_in_4_imag,
    input  logic [WIDTH-1:0] x_in_5_imag,
    input  logic [WIDTH-1:0] x_in_6_imag,
    input  logic [WIDTH-1:0] x_in_7_imag,
    output logic             in_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag,
    output logic [2:0]       out_index,
    output logic             out_last
);

    logic [WIDTH-1:0] in_re [8];
    logic [WIDTH-1:0] in_im [8];
    logic [WIDTH-1:0] bank_re [2][8];
    logic [WIDTH-1:0] bank_im [2][8];
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wb;
    logic             rb;
    logic [2:0]       cnt;
    logic [2:0]       rd_idx;
    logic             capture;
    logic             drop;
    logic             beat;
    logic             rel_bank;

    assign in_re[0] = x_in_0_real;
    assign in_re[1] = x_in_1_real;
    assign in_re[2] = x_in_2_real;
    assign in_re[3] = x_in_3_real;
    assign in_re[4] = x_in_4_real;
    assign in_re[5] = x_in_5_real;
    assign in_re[6] = x_in_6_real;
    assign in_re[7] = x_in_7_real;
    assign in_im[0] = x_in_0_imag;
    assign in_im[1] = x_in_1_imag;
    assign in_im[2] = x_in_2_imag;
    assign in_im[3] = x_in_3_imag;
    assign in_im[4] = x_in_4_imag;
    assign in_im[5] = x_in_5_imag;
    assign in_im[6] = x_in_6_imag;
    assign in_im[7] = x_in_7_imag;

    // in_ready depends on registers only; a bank freed this cycle is reusable next cycle
    assign in_ready = ~full[wb];
    assign capture  = in_valid & ~full[wb];
    assign drop     = in_valid & full[wb];
    assign beat     = full[rb] & out_ready;
    assign rel_bank = beat & (cnt == 3'd7);
    assign rd_idx   = REORDER ? {cnt[0], cnt[1], cnt[2]} : cnt;

    always_comb begin
        full_nxt = full;
        if (capture)
            full_nxt[wb] = 1'b1;
        if (rel_bank)
            full_nxt[rb] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    bank_re[b][i] <= '0;
                    bank_im[b][i] <= '0;
                end
            end
        end else if (capture) begin
            for (int i = 0; i < 8; i++) begin
                bank_re[wb][i] <= in_re[i];
                bank_im[wb][i] <= in_im[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            wb      <= 1'b0;
            rb      <= 1'b0;
            cnt     <= 3'd0;
            overrun <= 1'b0;
        end else begin
            full <= full_nxt;
            if (capture)
                wb <= ~wb;
            if (beat) begin
                if (cnt == 3'd7) begin
                    cnt <= 3'd0;
                    rb  <= ~rb;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end
            if (drop)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign out_valid = full[rb];
    assign out_index = cnt;
    assign out_last  = full[rb] & (cnt == 3'd7);
    assign out_real  = full[rb] ? bank_re[rb][rd_idx] : '0;
    assign out_imag  = full[rb] ? bank_im[rb][rd_idx] : '0;

endmodule

// File: tb/tb_fft_output_serializer.sv
// Scoreboard bench: REORDER=1 and REORDER=0 instances share stimulus; a frame-level
// model predicts acceptance and the expected beat streams.
module tb_fft_output_serializer;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        overrun_clr;
    logic        out_ready;
    logic [15:0] fr_re [8];
    logic [15:0] fr_im [8];

    logic        in_ready1, overrun1, out_valid1, out_last1;
    logic [15:0] out_real1, out_imag1;
    logic [2:0]  out_index1;
    logic        in_ready0, overrun0, out_valid0, out_last0;
    logic [15:0] out_real0, out_imag0;
    logic [2:0]  out_index0;

    beat_t q1[$];
    beat_t q0[$];
    int    accepted = 0;
    int    released = 0;
    int    beats = 0;
    bit    model_ov = 1'b0;
    int    rmode = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    fft_output_serializer #(.WIDTH(16), .REORDER(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x_in_0_real(fr_re[0]), .x_in_1_real(fr_re[1]), .x_in_2_real(fr_re[2]), .x_in_3_real(fr_re[3]),
        .x_in_4_real(fr_re[4]), .x_in_5_real(fr_re[5]), .x_in_6_real(fr_re[6]), .x_in_7_real(fr_re[7]),
        .x_in_0_imag(fr_im[0]), .x_in_1_imag(fr_im[1]), .x_in_2_imag(fr_im[2]), .x_in_3_imag(fr_im[3]),
        .x_in_4_imag(fr_im[4]), .x_in_5_imag(fr_im[5]), .x_in_6_imag(fr_im[6]), .x_in_7_imag(fr_im[7]),
        .in_ready(in_ready1), .overrun(overrun1), .overrun_clr(overrun_clr),
        .out_valid(out_valid1), .out_ready(out_ready), .out_real(out_real1), .out_imag(out_imag1),
        .out_index(out_index1), .out_last(out_last1)
    );

    fft_output_serializer #(.WIDTH(16), .REORDER(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x_in_0_real(fr_re[0]), .x_in_1_real(fr_re[1]), .x_in_2_real(fr_re[2]), .x_in_3_real(fr_re[3]),
        .x_in_4_real(fr_re[4]), .x_in_5_real(fr_re[5]), .x_in_6_real(fr_re[6]), .x_in_7_real(fr_re[7]),
        .x_in_0_imag(fr_im[0]), .x_in_1_imag(fr_im[1]), .x_in_2_imag(fr_im[2]), .x_in_3_imag(fr_im[3]),
        .x_in_4_imag(fr_im[4]), .x_in_5_imag(fr_im[5]), .x_in_6_imag(fr_im[6]), .x_in_7_imag(fr_im[7]),
        .in_ready(in_ready0), .overrun(overrun0), .overrun_clr(overrun_clr),
        .out_valid(out_valid0), .out_ready(out_ready), .out_real(out_real0), .out_imag(out_imag0),
        .out_index(out_index0), .out_last(out_last0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bitrev3(input int k);
        return ((k % 2) * 4) + (((k / 2) % 2) * 2) + ((k / 4) % 2);
    endfunction

    // Expected beats for the frame currently on the inputs, in emission order.
    task automatic push_frame();
        for (int k = 0; k < 8; k++) begin
            q1.push_back('{fr_re[bitrev3(k)], fr_im[bitrev3(k)], 3'(k), k == 7});
            q0.push_back('{fr_re[k], fr_im[k], 3'(k), k == 7});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        overrun_clr = 1'b0;
        case (rmode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // A frame is accepted iff fewer than two frames are held when the strobe arrives.
    task automatic pulse();
        bit acc;
        bit clr;
        acc = (accepted - released) < 2;
        clr = overrun_clr;
        chk("in_ready_at_pulse", {31'd0, in_ready1}, {31'd0, acc});
        in_valid = 1'b1;
        tick();
        if (acc) begin
            push_frame();
            accepted++;
        end else begin
            model_ov = 1'b1;
        end
        if (acc && clr)
            model_ov = 1'b0;
    endtask

    task automatic clear_ov();
        overrun_clr = 1'b1;
        tick();
        model_ov = 1'b0;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 16'($urandom);
            fr_im[k] = 16'($urandom);
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && q1.size() > 0; i++)
            tick();
        chk("drain_empty", q1.size(), 0);
        chk("drain_valid1", {31'd0, out_valid1}, 0);
        chk("drain_valid0", {31'd0, out_valid0}, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            automatic bit exp_v = (accepted - released) > 0;
            chk("out_valid1", {31'd0, out_valid1}, {31'd0, exp_v});
            chk("out_valid0", {31'd0, out_valid0}, {31'd0, exp_v});
            chk("overrun1", {31'd0, overrun1}, {31'd0, model_ov});
            chk("overrun0", {31'd0, overrun0}, {31'd0, model_ov});
            chk("in_ready1", {31'd0, in_ready1}, {31'd0, (accepted - released) < 2});
            if (out_valid1 && q1.size() > 0) begin
                chk("real1", {16'd0, out_real1}, {16'd0, q1[0].re});
                chk("imag1", {16'd0, out_imag1}, {16'd0, q1[0].im});
                chk("index1", {29'd0, out_index1}, {29'd0, q1[0].idx});
                chk("last1", {31'd0, out_last1}, {31'd0, q1[0].last});
            end else if (out_valid1) begin
                chk("sb_underflow1", q1.size(), 1);
            end else begin
                chk("idle_real1", {16'd0, out_real1}, 0);
                chk("idle_last1", {31'd0, out_last1}, 0);
            end
            if (out_valid0 && q0.size() > 0) begin
                chk("real0", {16'd0, out_real0}, {16'd0, q0[0].re});
                chk("imag0", {16'd0, out_imag0}, {16'd0, q0[0].im});
                chk("index0", {29'd0, out_index0}, {29'd0, q0[0].idx});
                chk("last0", {31'd0, out_last0}, {31'd0, q0[0].last});
            end
            if (out_valid1 && out_ready && q1.size() > 0) begin
                if (q1[0].last)
                    released++;
                void'(q1.pop_front());
                if (q0.size() > 0)
                    void'(q0.pop_front());
                beats++;
            end
        end
    end

    initial begin
        int b0;
        bit found;
        rst = 1'b1;
        in_valid = 1'b0;
        overrun_clr = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = '0;
            fr_im[k] = '0;
        end

        // reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready1}, 1);
        chk("rst_out_valid", {31'd0, out_valid1}, 0);
        chk("rst_overrun", {31'd0, overrun1}, 0);
        chk("rst_out_real", {16'd0, out_real1}, 0);
        chk("rst_out_imag", {16'd0, out_imag1}, 0);
        chk("rst_out_index", {29'd0, out_index1}, 0);
        chk("rst_out_last", {31'd0, out_last1}, 0);
        chk("rst_out_valid0", {31'd0, out_valid0}, 0);

        // directed frame, full throughput
        rmode = 1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 16'(100 + k);
            fr_im[k] = 16'(-k);
        end
        b0 = beats;
        pulse();
        drain(20);
        chk("frame_beats", beats - b0, 8);

        // alternate-cycle backpressure: 8 beats in exactly 16 cycles
        rmode = 0;
        out_ready = 1'b0;
        pulse();
        rmode = 2;
        repeat (15) tick();
        chk("bp_one_left", q1.size(), 1);
        tick();
        chk("bp_done", q1.size(), 0);
        chk("bp_valid_low", {31'd0, out_valid1}, 0);

        // overrun: third back-to-back frame dropped
        rmode = 0;
        b0 = beats;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            pulse();
        end
        chk("ov_set", {31'd0, overrun1}, 1);
        clear_ov();
        chk("ov_cleared", {31'd0, overrun1}, 0);
        rmode = 1;
        drain(40);
        chk("ov_drain_beats", beats - b0, 16);

        // drop coinciding with clear: set wins
        rmode = 0;
        rand_frame(); pulse();
        rand_frame(); pulse();
        overrun_clr = 1'b1;
        rand_frame(); pulse();
        chk("ov_set_wins", {31'd0, overrun1}, 1);
        clear_ov();
        rmode = 1;
        drain(40);

        // ping-pong streaming, one frame per 8 cycles
        rmode = 1;
        b0 = beats;
        for (int f = 0; f < 8; f++) begin
            rand_frame();
            pulse();
            repeat (7) tick();
        end
        drain(20);
        chk("stream_beats", beats - b0, 64);
        chk("stream_no_ov", {31'd0, overrun1}, 0);

        // random traffic with random backpressure
        rmode = 3;
        for (int i = 0; i < 40; i++) begin
            rand_frame();
            if ($urandom_range(0, 4) == 0)
                overrun_clr = 1'b1;
            pulse();
            repeat ($urandom_range(0, 12)) tick();
        end
        rmode = 1;
        drain(60);
        clear_ov();

        // reset in the middle of a frame with a second frame buffered
        rand_frame(); pulse();
        rand_frame(); pulse();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid1 && out_index1 == 3'd3)
                found = 1'b1;
        end
        chk("mid_found_beat3", {31'd0, found}, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid1", {31'd0, out_valid1}, 0);
        chk("mid_rst_valid0", {31'd0, out_valid0}, 0);
        chk("mid_rst_real", {16'd0, out_real1}, 0);
        chk("mid_rst_index", {29'd0, out_index1}, 0);
        q1.delete();
        q0.delete();
        accepted = 0;
        released = 0;
        model_ov = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready1}, 1);
        b0 = beats;
        repeat (12) tick();
        chk("post_rst_no_beats", beats - b0, 0);
        chk("post_rst_valid", {31'd0, out_valid1}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
